fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_pc_reg.sv | 52 +++++
 rtl/fetch_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module : fetch_unit_pkg
// Brief  : Shared CPU definitions: fetch FSM encoding and fetch defaults.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          MAX_WAIT_DEFAULT = 16;
  localparam int          WAIT_W           = 8;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_pc_reg.sv
// ============================================================================
// Module : pc_reg
// Brief  : Program counter with next-PC mux (branch target / PC+4) and PC+8.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        pc_en_i,
  input  logic        pcsrc_i,
  input  logic [31:0] result_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus8_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  // Branch targets are forced word-aligned; adders wrap modulo 2^32.
  assign w_target   = result_i & ~32'h0000_0003;
  assign w_pc_plus4 = pc_q + 32'd4;
  assign pc_plus8_o = pc_q + 32'd8;
  assign pc_o       = pc_q;

  // Next-PC selection: only advances when the fetch FSM retires an instruction.
  always_comb begin
    pc_d = pc_q;
    if (pc_en_i) begin
      pc_d = pcsrc_i ? w_target : w_pc_plus4;
    end
  end

  // PC register with asynchronous reset to the boot address.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Brief  : Multi-cycle instruction fetch FSM with wait timeout and PC unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  input  logic        Hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  output logic        FetchErr
);

  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  fetch_state_e       state_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [31:0]        instr_q;
  logic               imem_req_q;
  logic               instr_valid_q;
  logic               fetch_err_q;
  logic               w_pc_en;

  // The PC moves only when an executing instruction is released by Hold.
  assign w_pc_en = (state_q == ST_EXEC) && !Hold;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_ni     (Reset),
    .pc_en_i    (w_pc_en),
    .pcsrc_i    (PCSrc),
    .result_i   (Result),
    .pc_o       (PC),
    .pc_plus8_o (PCPlus8)
  );

  assign imem_addr  = PC;
  assign imem_req   = imem_req_q;
  assign Instr      = instr_q;
  assign InstrValid = instr_valid_q;
  assign FetchErr   = fetch_err_q;

  // Fetch FSM with registered outputs; HALT is left only through reset.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= ST_IDLE;
      wait_q        <= '0;
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            instr_q       <= imem_rdata;
            wait_q        <= '0;
            state_q       <= ST_EXEC;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end else if (wait_q == C_WAIT_LAST) begin
            fetch_err_q <= 1'b1;
            state_q     <= ST_HALT;
            imem_req_q  <= 1'b0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_EXEC: begin
          if (!Hold) begin
            state_q       <= ST_FETCH;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        ST_HALT: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
